// File: rtl/counter_log_uart.sv
// counter_log_uart: fills a RAM with a stepping counter, then dumps every word over a UART line.
// Words are sent as back-to-back frames, least-significant byte first.
module counter_log_uart #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int STEP    = 1,
  parameter int CLK_DIV = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] count,
  output logic [ADDR_W-1:0] address_out,
  output logic [1:0]        state_out
);
  localparam int NBYTES = DATA_W / 8;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BYTE_W = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DUMP, S_DONE} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  logic [7:0] w_byte;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0] r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic r_load, r_tx;
  logic w_bit_end, w_frame_end, w_word_end, w_last_addr;
  assign w_last_addr = &address_out;
  assign w_bit_end   = r_baud == BAUD_W'(CLK_DIV - 1);
  assign w_frame_end = w_bit_end && r_bit == 4'd9;
  assign w_word_end  = w_frame_end && r_byte == BYTE_W'(NBYTES - 1);
  assign w_byte      = 8'(r_rdata >> {r_byte, 3'b000});
  assign busy        = r_state == S_FILL || r_state == S_DUMP;
  assign done        = r_state == S_DONE;
  assign state_out   = r_state;
  assign tx          = r_tx;
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && start) w_next = S_FILL;
    if (r_state == S_FILL && w_last_addr) w_next = S_DUMP;
    if (r_state == S_DUMP && !r_load && w_word_end && w_last_addr) w_next = S_DONE;
    if (r_state == S_DONE) w_next = S_IDLE;
    if (busy && abort) w_next = S_IDLE;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // r_tx holds the level of the bit that the next cycle will present
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count       <= '0;
      address_out <= '0;
      r_tx        <= 1'b1;
      r_baud      <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_load      <= 1'b0;
    end else if (busy && abort) begin
      address_out <= '0;
      r_tx        <= 1'b1;
      r_baud      <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_load      <= 1'b0;
    end else if (r_state == S_FILL) begin
      count       <= count + DATA_W'(STEP);
      address_out <= address_out + 1'b1;
      r_load      <= 1'b1;
    end else if (r_state == S_DUMP) begin
      if (r_load) begin
        r_load <= 1'b0;
        r_tx   <= 1'b0;
      end else begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          r_bit <= w_frame_end ? 4'd0 : r_bit + 4'd1;
          r_tx  <= w_frame_end ? w_word_end : (r_bit == 4'd8 || w_byte[r_bit[2:0]]);
        end
        if (w_frame_end) r_byte <= w_word_end ? '0 : r_byte + 1'b1;
        if (w_word_end) begin
          r_load      <= 1'b1;
          address_out <= address_out + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (r_state == S_FILL && !abort) r_mem[address_out] <= count;
    if (r_load) r_rdata <= r_mem[address_out];
  end
endmodule

// File: tb/tb_counter_log_uart.sv
// tb_counter_log_uart: scoreboard bench; stimulus queues expected UART bytes, a monitor decodes tx and compares.
module tb_counter_log_uart;
  localparam int CD = 4;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0, ab0 = 1'b0;
  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] cnt0, cnt1;
  logic [15:0] cnt2;
  logic [1:0] a0, a1, a2, s0, s1, s2;
  int sel = 0;
  logic kill = 1'b0;
  logic m_tx, m_busy, m_done;
  logic [1:0] m_state;
  logic [7:0] exp_q[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk_in = ~clk_in;

  counter_log_uart #(.DATA_W(8), .ADDR_W(2), .STEP(1), .CLK_DIV(CD)) u0 (
    .clk_in(clk_in), .rst(rst), .start(st0), .abort(ab0), .tx(tx0), .busy(busy0),
    .done(done0), .count(cnt0), .address_out(a0), .state_out(s0));
  counter_log_uart #(.DATA_W(8), .ADDR_W(2), .STEP(8'h60), .CLK_DIV(CD)) u1 (
    .clk_in(clk_in), .rst(rst), .start(st1), .abort(1'b0), .tx(tx1), .busy(busy1),
    .done(done1), .count(cnt1), .address_out(a1), .state_out(s1));
  counter_log_uart #(.DATA_W(16), .ADDR_W(2), .STEP(16'h0102), .CLK_DIV(CD)) u2 (
    .clk_in(clk_in), .rst(rst), .start(st2), .abort(1'b0), .tx(tx2), .busy(busy2),
    .done(done2), .count(cnt2), .address_out(a2), .state_out(s2));

  always_comb begin
    m_tx    = sel == 0 ? tx0 : sel == 1 ? tx1 : tx2;
    m_busy  = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
    m_done  = sel == 0 ? done0 : sel == 1 ? done1 : done2;
    m_state = sel == 0 ? s0 : sel == 1 ? s1 : s2;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  task automatic measure(input int s, input bit hold, output int bc, output int dn);
    bc = 0;
    dn = 0;
    set_start(s, 1'b1);
    tick();
    if (!hold) set_start(s, 1'b0);
    for (int t = 0; t < 3000 && m_state != 2'd0; t++) begin
      bc += int'(m_busy);
      dn += int'(m_done);
      if (hold && m_done) set_start(s, 1'b0);
      tick();
    end
    set_start(s, 1'b0);
  endtask

  // UART monitor: samples each bit near its start, discards frames overlapped by kill
  initial forever begin
    @(negedge clk_in);
    if (m_tx === 1'b0 && !rst) begin
      logic [8:0] got;
      logic ok;
      ok = !kill;
      got = '0;
      for (int c = 1; c < 10 * CD; c++) begin
        @(negedge clk_in);
        if (kill) ok = 1'b0;
        if (c % CD == 0) got[c / CD - 1] = m_tx;
      end
      if (ok) begin
        if (exp_q.size() == 0) chk("frame_unexpected", exp_q.size(), 1);
        else chk("frame", got, {1'b1, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int bc, dn;
    repeat (3) tick();
    chk("rst_tx", tx0, 1);
    chk("rst_count", cnt0, 0);
    chk("rst_state", s0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_addr", a0, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    measure(0, 1'b0, bc, dn);
    chk("run1_busy", bc, 168);
    chk("run1_done", dn, 1);
    chk("run1_state", s0, 0);
    chk("run1_count", cnt0, 8'h04);
    for (int i = 4; i < 8; i++) exp_q.push_back(8'(i));
    measure(0, 1'b0, bc, dn);
    chk("run2_busy", bc, 168);
    chk("run2_count", cnt0, 8'h08);
    exp_q.push_back(8'h08);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int t = 0; t < 20 && s0 != 2'd2; t++) tick();
    repeat (52) tick();
    chk("abort_pre_tx", tx0, 0);
    chk("abort_pre_addr", a0, 1);
    ab0 = 1'b1;
    kill = 1'b1;
    tick();
    ab0 = 1'b0;
    chk("abort_tx", tx0, 1);
    chk("abort_state", s0, 0);
    chk("abort_count", cnt0, 8'h0C);
    dn = 0;
    repeat (50) begin
      dn += int'(done0);
      tick();
    end
    chk("abort_no_done", dn, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    kill = 1'b0;
    for (int i = 12; i < 16; i++) exp_q.push_back(8'(i));
    measure(0, 1'b0, bc, dn);
    chk("post_abort_busy", bc, 168);
    chk("post_abort_count", cnt0, 8'h10);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(i));
    measure(0, 1'b1, bc, dn);
    chk("hold_busy", bc, 168);
    chk("hold_done", dn, 1);
    chk("hold_state", s0, 0);
    chk("hold_count", cnt0, 8'h14);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    for (int t = 0; t < 20 && s0 != 2'd2; t++) tick();
    for (int t = 0; t < 10 && tx0 != 1'b0; t++) tick();
    chk("rst_mid_pre_tx", tx0, 0);
    @(negedge clk_in);
    kill = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx0, 1);
    chk("rst_mid_count", cnt0, 0);
    chk("rst_mid_state", s0, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (50) tick();
    kill = 1'b0;
    sel = 1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'h20);
    measure(1, 1'b0, bc, dn);
    chk("wrap_busy", bc, 168);
    chk("wrap_count", cnt1, 8'h80);
    sel = 2;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h03);
    measure(2, 1'b0, bc, dn);
    chk("wide_busy", bc, 328);
    chk("wide_done", dn, 1);
    chk("wide_count", cnt2, 16'h0408);
    repeat (10) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
